// File: rtl/button_debouncer_pkg.sv
// Shared types and helpers for the push-button debouncer: FSM state encoding
// and the counter-width helper used to size the debounce/hold/repeat counters.
package button_debouncer_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_DB   = 2'd1,
    PRESSED    = 2'd2,
    RELEASE_DB = 2'd3
  } state_e;

  // Bits needed to hold the values 0..max_val inclusive.
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/button_debouncer_sync_2ff.sv
// Two-flop synchroniser for a single raw asynchronous input; resets to 0 so a
// held input is seen as a fresh edge after reset.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/button_debouncer.sv
// Push-button debouncer: synchronises a raw button, accepts level changes after
// DEBOUNCE_CYCLES stable samples, and emits press/release/auto-repeat strobes.
module button_debouncer
  import button_debouncer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned HOLD_CYCLES     = 50_000_000,
  parameter int unsigned REPEAT_CYCLES   = 10_000_000,
  parameter bit          REPEAT_EN       = 1'b1
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_btn,
  output logic o_btn_level,
  output logic o_press_pulse,
  output logic o_release_pulse,
  output logic o_repeat_pulse,
  output logic o_event
);

  localparam int DB_W   = cnt_w(DEBOUNCE_CYCLES);
  localparam int HOLD_W = cnt_w(HOLD_CYCLES);
  localparam int REP_W  = cnt_w(REPEAT_CYCLES);

  localparam logic [DB_W-1:0]   DB_MAX    = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CYCLES - 1);

  logic btn_s;

  sync_2ff u_sync (
    .clk_i (i_clk),
    .rst_i (i_reset),
    .d_i   (i_btn),
    .q_o   (btn_s)
  );

  state_e            state_q, state_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [REP_W-1:0]  rep_cnt_q, rep_cnt_d;
  logic              level_q, level_d;
  logic              press_q, press_d;
  logic              release_q, release_d;
  logic              repeat_q, repeat_d;
  logic              event_q, event_d;

  always_comb begin
    state_d    = state_q;
    db_cnt_d   = db_cnt_q;
    hold_cnt_d = hold_cnt_q;
    rep_cnt_d  = rep_cnt_q;
    press_d    = 1'b0;
    release_d  = 1'b0;
    repeat_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (btn_s) begin
          state_d  = PRESS_DB;
          db_cnt_d = DB_ONE;
        end
      end
      PRESS_DB: begin
        if (!btn_s) begin
          state_d  = IDLE;
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_MAX) begin
          state_d  = PRESSED;
          db_cnt_d = '0;
          press_d  = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
      PRESSED: begin
        if (!btn_s) begin
          state_d  = RELEASE_DB;
          db_cnt_d = DB_ONE;
        end
        // Hold timer saturates at HOLD_MAX; only then does the repeat timer run.
        if (hold_cnt_q != HOLD_MAX) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
          repeat_d   = REPEAT_EN && (hold_cnt_q == HOLD_LAST);
        end else if (rep_cnt_q == REP_LAST) begin
          rep_cnt_d = '0;
          repeat_d  = REPEAT_EN;
        end else begin
          rep_cnt_d = rep_cnt_q + 1'b1;
        end
      end
      RELEASE_DB: begin
        if (btn_s) begin
          state_d  = PRESSED;
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_MAX) begin
          state_d   = IDLE;
          db_cnt_d  = '0;
          release_d = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d == IDLE) begin
      hold_cnt_d = '0;
      rep_cnt_d  = '0;
    end

    level_d = (state_d == PRESSED) || (state_d == RELEASE_DB);
    event_d = press_d | repeat_d;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= IDLE;
      db_cnt_q   <= '0;
      hold_cnt_q <= '0;
      rep_cnt_q  <= '0;
      level_q    <= 1'b0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      repeat_q   <= 1'b0;
      event_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      db_cnt_q   <= db_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      rep_cnt_q  <= rep_cnt_d;
      level_q    <= level_d;
      press_q    <= press_d;
      release_q  <= release_d;
      repeat_q   <= repeat_d;
      event_q    <= event_d;
    end
  end

  assign o_btn_level     = level_q;
  assign o_press_pulse   = press_q;
  assign o_release_pulse = release_q;
  assign o_repeat_pulse  = repeat_q;
  assign o_event         = event_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with DEBOUNCE=4, HOLD=20, REPEAT=8; a second
// instance with auto-repeat disabled shares the same stimulus.
module tb_button_debouncer;

  logic clk = 1'b0;
  logic rst;
  logic btn;

  logic lv, pr, rl, rp, ev;
  logic nr_lv, nr_pr, nr_rl, nr_rp, nr_ev;

  always #5 clk = ~clk;

  button_debouncer #(
    .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(20), .REPEAT_CYCLES(8), .REPEAT_EN(1'b1)
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_btn(btn),
    .o_btn_level(lv), .o_press_pulse(pr), .o_release_pulse(rl),
    .o_repeat_pulse(rp), .o_event(ev)
  );

  button_debouncer #(
    .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(20), .REPEAT_CYCLES(8), .REPEAT_EN(1'b0)
  ) dut_nr (
    .i_clk(clk), .i_reset(rst), .i_btn(btn),
    .o_btn_level(nr_lv), .o_press_pulse(nr_pr), .o_release_pulse(nr_rl),
    .o_repeat_pulse(nr_rp), .o_event(nr_ev)
  );

  int checks = 0;
  int errors = 0;
  int t = 0;
  int pr_n, pr_t, rl_n, rl_t, rp_n, ev_n, lv_n, bad_n;
  int nr_ev_n, nr_rp_n, nr_pr_n, nr_rl_n;
  int rp_q[$];
  int t0, pt, rt;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clr();
    pr_n = 0; pr_t = -1; rl_n = 0; rl_t = -1; rp_n = 0; ev_n = 0; lv_n = 0; bad_n = 0;
    nr_ev_n = 0; nr_rp_n = 0; nr_pr_n = 0; nr_rl_n = 0;
    rp_q.delete();
  endtask

  // Advance one clock; t names the edge just taken, outputs sampled 1 ns later.
  task automatic cyc();
    @(posedge clk);
    t++;
    #1;
    if (pr) begin pr_n++; pr_t = t; end
    if (rl) begin rl_n++; rl_t = t; end
    if (rp) begin rp_n++; rp_q.push_back(t); end
    if (ev) ev_n++;
    if (lv) lv_n++;
    if ((ev !== (pr | rp)) || (pr && rp)) bad_n++;
    if (nr_ev) nr_ev_n++;
    if (nr_rp) nr_rp_n++;
    if (nr_pr) nr_pr_n++;
    if (nr_rl) nr_rl_n++;
  endtask

  initial begin
    rst = 1'b1;
    btn = 1'b0;
    clr();
    repeat (3) cyc();
    chk("reset_level",   int'(lv), 0);
    chk("reset_pulses",  int'({pr, rl, rp, ev}), 0);
    chk("reset_state",   int'(dut.state_q), 0);
    rst = 1'b0;
    repeat (3) cyc();
    chk("idle_outputs",  int'({lv, pr, rl, rp, ev}), 0);

    // Clean press, 12 raw cycles high, release
    clr();
    t0 = t; btn = 1'b1;
    repeat (12) cyc();
    btn = 1'b0;
    rt = t + 1;
    repeat (12) cyc();
    chk("clean_press_n",   pr_n, 1);
    chk("clean_press_t",   pr_t, t0 + 7);
    chk("clean_release_n", rl_n, 1);
    chk("clean_release_t", rl_t, rt + 6);
    chk("clean_event_n",   ev_n, 1);
    chk("clean_repeat_n",  rp_n, 0);
    chk("clean_level_n",   lv_n, 12);
    chk("clean_level_end", int'(lv), 0);

    // Bounce that never settles long enough
    clr();
    btn = 1'b1; repeat (3) cyc();
    btn = 1'b0; repeat (2) cyc();
    btn = 1'b1; repeat (2) cyc();
    btn = 1'b0; repeat (10) cyc();
    chk("bounce_events",  ev_n + pr_n + rl_n + rp_n, 0);
    chk("bounce_level_n", lv_n, 0);
    chk("bounce_state",   int'(dut.state_q), 0);

    // Long hold with auto-repeat
    clr();
    t0 = t; pt = t0 + 7; btn = 1'b1;
    repeat (52) cyc();
    btn = 1'b0;
    repeat (12) cyc();
    chk("hold_press_t",  pr_t, pt);
    chk("hold_repeat_n", rp_n, 4);
    chk("hold_rep0",     rp_q[0], pt + 20);
    chk("hold_rep1",     rp_q[1], pt + 28);
    chk("hold_rep2",     rp_q[2], pt + 36);
    chk("hold_rep3",     rp_q[3], pt + 44);
    chk("hold_event_n",  ev_n, 5);
    chk("hold_release_t", rl_t, pt + 52);
    chk("hold_exclusive", bad_n, 0);

    // Release glitch while pressed: timers freeze for two cycles
    clr();
    t0 = t; pt = t0 + 7; btn = 1'b1;
    repeat (10) cyc();
    btn = 1'b0; repeat (2) cyc();
    btn = 1'b1; repeat (34) cyc();
    btn = 1'b0; repeat (12) cyc();
    chk("glitch_press_n",   pr_n, 1);
    chk("glitch_release_n", rl_n, 1);
    chk("glitch_release_t", rl_t, pt + 46);
    chk("glitch_level_n",   lv_n, 46);
    chk("glitch_repeat_n",  rp_n, 3);
    chk("glitch_rep0",      rp_q[0], pt + 22);
    chk("glitch_rep1",      rp_q[1], pt + 30);
    chk("glitch_rep2",      rp_q[2], pt + 38);
    chk("glitch_event_n",   ev_n, 4);

    // Reset while the button is held
    clr();
    t0 = t; btn = 1'b1;
    repeat (12) cyc();
    chk("prerst_level", int'(lv), 1);
    rst = 1'b1;
    cyc();
    rt = t;
    chk("rst_outputs", int'({lv, pr, rl, rp, ev}), 0);
    rst = 1'b0;
    clr();
    repeat (10) cyc();
    chk("rst_press_n", pr_n, 1);
    chk("rst_press_t", pr_t, rt + 7);
    chk("rst_level",   int'(lv), 1);
    btn = 1'b0;
    repeat (12) cyc();

    // 100-cycle hold: repeat instance vs non-repeat instance
    clr();
    t0 = t; pt = t0 + 7; btn = 1'b1;
    repeat (107) cyc();
    btn = 1'b0;
    repeat (12) cyc();
    chk("norep_event_n",   nr_ev_n, 1);
    chk("norep_repeat_n",  nr_rp_n, 0);
    chk("norep_press_n",   nr_pr_n, 1);
    chk("norep_release_n", nr_rl_n, 1);
    chk("rep100_event_n",  ev_n, 12);
    chk("rep100_last",     rp_q[10], pt + 100);
    chk("rep100_exclusive", bad_n, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
